pc_gen: RTL and testbench

- Program-counter stage directly upstream of instruction fetch.
- Holds the word-indexed PC that drives the fetch stage's 10-bit `pc` input, which reads the 1024-word instruction memory.
- Selects the next PC from sequential increment, taken branch, jump, stall hold, or halt.
- Provides a small run-control state machine and a retired-fetch counter for debug and perf.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/next_pc_mux.sv | 42 ++++
 rtl/pc_gen.sv | 92 +++++++++
 tb/tb_pc_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC geometry, run-control states and
// the opcodes that drive the branch and jump resolvers.
package cpu_pkg;

    localparam int unsigned PC_W     = 10;
    localparam int unsigned RESET_PC = 0;

    localparam logic [5:0] OpBeq = 6'h04;
    localparam logic [5:0] OpJ   = 6'h02;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalt
    } pc_state_e;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection for the RUN state: jump > branch > stall > sequential.
// Assumes PC_W <= 16 so the branch offset slice is always in range.
module next_pc_mux #(
    parameter int unsigned PC_W = 10
) (
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [15:0]     branch_offset,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    output logic [PC_W-1:0] pc_plus1,
    output logic [PC_W-1:0] next_pc,
    output logic            advance
);
    import cpu_pkg::*;

    logic [PC_W-1:0] branch_pc;
    logic            redirect;
    logic            unused_bits;

    assign pc_plus1  = pc + PC_W'(1);
    // Truncating the offset keeps two's-complement wrap modulo 2^PC_W.
    assign branch_pc = pc_plus1 + branch_offset[PC_W-1:0];
    assign redirect  = jump | branch_taken;
    assign advance   = redirect | ~stall;

    // Upper offset and target bits are deliberately dropped.
    assign unused_bits = ^{branch_offset, jump_target};

    always_comb begin
        next_pc = pc;
        if (jump) begin
            next_pc = jump_target[PC_W-1:0];
        end else if (branch_taken) begin
            next_pc = branch_pc;
        end else if (!stall) begin
            next_pc = pc_plus1;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter stage: run-control FSM (BOOT/RUN/HALT), PC register and a
// saturating count of accepted fetches.
module pc_gen #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus1,
    output logic             fetch_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);
    import cpu_pkg::*;

    pc_state_e        state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  run_next_pc;
    logic             advance;

    next_pc_mux #(
        .PC_W(PC_W)
    ) u_next_pc_mux (
        .pc            (pc_q),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_plus1      (pc_plus1),
        .next_pc       (run_next_pc),
        .advance       (advance)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StBoot: begin
                state_d = halt_req ? StHalt : StRun;
            end
            StRun: begin
                // Halt outranks any redirect and freezes the PC.
                if (halt_req) begin
                    state_d = StHalt;
                end else begin
                    pc_d = run_next_pc;
                    if (advance && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StHalt: begin
                if (resume && !halt_req) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= PC_W'(RESET_PC);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == StRun);
    assign halted      = (state_q == StHalt);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_pc_gen;

    localparam int          PcMod  = 1024;
    localparam longint      CntMax = (64'd1 << 32) - 1;
    localparam int          MBoot  = 0;
    localparam int          MRun   = 1;
    localparam int          MHalt  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        halt_req;
    logic        resume;
    logic [9:0]  pc;
    logic [9:0]  pc_plus1;
    logic        fetch_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    int          m_mode;
    int          m_pc;
    longint      m_cnt;
    longint      saved_cnt;

    always #5 clk = ~clk;

    pc_gen #(
        .PC_W     (10),
        .RESET_PC (0),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .fetch_valid   (fetch_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: applies the sampled inputs of one rising edge.
    task automatic model_edge();
        int off;
        int tmp;
        if (rst) begin
            m_mode = MBoot;
            m_pc   = 0;
            m_cnt  = 0;
        end else if (m_mode == MBoot) begin
            m_mode = halt_req ? MHalt : MRun;
        end else if (m_mode == MRun) begin
            if (halt_req) begin
                m_mode = MHalt;
            end else begin
                if (jump || branch_taken || !stall) begin
                    if (m_cnt < CntMax) m_cnt = m_cnt + 1;
                end
                if (jump) begin
                    m_pc = int'(jump_target) % PcMod;
                end else if (branch_taken) begin
                    off  = int'($signed(branch_offset));
                    tmp  = m_pc + 1 + off;
                    m_pc = ((tmp % PcMod) + PcMod) % PcMod;
                end else if (!stall) begin
                    m_pc = (m_pc + 1) % PcMod;
                end
            end
        end else begin
            if (resume && !halt_req) m_mode = MRun;
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".pc"}, 64'(pc), 64'(m_pc));
        check_eq({tag, ".pc_plus1"}, 64'(pc_plus1), 64'((m_pc + 1) % PcMod));
        check_eq({tag, ".fetch_valid"}, 64'(fetch_valid), 64'(m_mode == MRun));
        check_eq({tag, ".halted"}, 64'(halted), 64'(m_mode == MHalt));
        check_eq({tag, ".fetch_count"}, 64'(fetch_count), 64'(m_cnt));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        rst           = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'h0;
        jump          = 1'b0;
        jump_target   = 26'h0;
        halt_req      = 1'b0;
        resume        = 1'b0;
    endtask

    task automatic jump_to(input int target);
        idle_inputs();
        jump        = 1'b1;
        jump_target = 26'(target);
        step("jump_to");
        idle_inputs();
    endtask

    initial begin
        m_mode = MBoot;
        m_pc   = 0;
        m_cnt  = 0;
        idle_inputs();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
        check_eq("reset_pc", 64'(pc), 64'd0);
        check_eq("reset_boot_fv", 64'(fetch_valid), 64'd0);
        check_eq("reset_count", 64'(fetch_count), 64'd0);

        // Free run out of BOOT
        step("run1");
        check_eq("run1_pc", 64'(pc), 64'd0);
        check_eq("run1_fv", 64'(fetch_valid), 64'd1);
        for (int i = 0; i < 4; i++) step("run");
        check_eq("run5_pc", 64'(pc), 64'd4);
        check_eq("run5_count", 64'(fetch_count), 64'd4);

        // Branch forward and backward with wrap
        branch_taken  = 1'b1;
        branch_offset = 16'h002A;
        step("br_fwd");
        check_eq("br_fwd_pc", 64'(pc), 64'd47);
        jump_to(4);
        branch_taken  = 1'b1;
        branch_offset = 16'hFFFA;
        step("br_back");
        idle_inputs();
        check_eq("br_back_pc", 64'(pc), 64'd1023);

        // Sequential wrap at top of memory
        step("wrap");
        check_eq("wrap_pc", 64'(pc), 64'd0);
        check_eq("wrap_pc_plus1", 64'(pc_plus1), 64'd1);

        // Jump beats branch, upper target bits dropped
        jump_to(6);
        jump          = 1'b1;
        branch_taken  = 1'b1;
        branch_offset = 16'h0005;
        jump_target   = 26'h3FF_FC07;
        step("jmp_br");
        idle_inputs();
        check_eq("jmp_br_pc", 64'(pc), 64'd7);

        // Stall holds, redirect overrides stall
        jump_to(9);
        saved_cnt = m_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            check_eq("stall_pc", 64'(pc), 64'd9);
            check_eq("stall_count", 64'(fetch_count), 64'(saved_cnt));
        end
        branch_taken  = 1'b1;
        branch_offset = 16'h0002;
        step("stall_br");
        idle_inputs();
        check_eq("stall_br_pc", 64'(pc), 64'd12);

        // Halt, ignore jumps, resume, then reset while halted
        jump_to(8);
        halt_req = 1'b1;
        step("halt");
        idle_inputs();
        check_eq("halt_halted", 64'(halted), 64'd1);
        check_eq("halt_fv", 64'(fetch_valid), 64'd0);
        jump        = 1'b1;
        jump_target = 26'd100;
        for (int i = 0; i < 4; i++) begin
            step("halt_jmp");
            check_eq("halt_jmp_pc", 64'(pc), 64'd8);
        end
        idle_inputs();
        resume = 1'b1;
        step("resume");
        idle_inputs();
        check_eq("resume_fv", 64'(fetch_valid), 64'd1);
        check_eq("resume_pc", 64'(pc), 64'd8);
        step("post_resume");
        check_eq("post_resume_pc", 64'(pc), 64'd9);
        halt_req = 1'b1;
        step("halt2");
        idle_inputs();
        rst = 1'b1;
        step("halt_rst");
        idle_inputs();
        check_eq("halt_rst_pc", 64'(pc), 64'd0);
        check_eq("halt_rst_halted", 64'(halted), 64'd0);
        check_eq("halt_rst_fv", 64'(fetch_valid), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            halt_req      = ($urandom_range(0, 15) == 0);
            resume        = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_offset = 16'($urandom);
            jump_target   = 26'($urandom);
            step("rand");
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
